// File: rtl/aes_regs_pkg.sv
// Shared constants for the AES Avalon-MM register slice.
// Holds the register-map word addresses, the VERSION readback value and the
// control state encoding used by aes_avalon_regs.
package aes_regs_pkg;

  localparam logic [3:0] ADDR_KEY0    = 4'd0;
  localparam logic [3:0] ADDR_KEY1    = 4'd1;
  localparam logic [3:0] ADDR_KEY2    = 4'd2;
  localparam logic [3:0] ADDR_KEY3    = 4'd3;
  localparam logic [3:0] ADDR_MSG0    = 4'd4;
  localparam logic [3:0] ADDR_MSG1    = 4'd5;
  localparam logic [3:0] ADDR_MSG2    = 4'd6;
  localparam logic [3:0] ADDR_MSG3    = 4'd7;
  localparam logic [3:0] ADDR_DEC0    = 4'd8;
  localparam logic [3:0] ADDR_DEC1    = 4'd9;
  localparam logic [3:0] ADDR_DEC2    = 4'd10;
  localparam logic [3:0] ADDR_DEC3    = 4'd11;
  localparam logic [3:0] ADDR_CYCLES  = 4'd12;
  localparam logic [3:0] ADDR_VERSION = 4'd13;
  localparam logic [3:0] ADDR_START   = 4'd14;
  localparam logic [3:0] ADDR_DONE    = 4'd15;

  localparam logic [31:0] VERSION = 32'h0385_0009;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_regs_state_t;

endpackage

// File: rtl/aes_reg_word.sv
// 32-bit software-writable register with per-byte write enables.
// Ports:
//   clk_i      clock
//   rst_i      synchronous clear (active-high)
//   we_i       write strobe (address already decoded)
//   inhibit_i  blocks writes while asserted
//   be_i       byte enables
//   wdata_i    write data
//   q_o        current register value
module aes_reg_word
  import aes_regs_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        inhibit_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);

  logic [31:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we_i && !inhibit_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) q_d[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/aes_avalon_regs.sv
// Avalon-MM register file feeding the AES decryption core.
// Holds key (regs 0-3) and ciphertext (regs 4-7), drives the core's start,
// captures plaintext (regs 8-11) on completion, and exposes a BUSY cycle
// counter (12), VERSION (13), START (14) and DONE (15).
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   AVL_*               Avalon-MM slave; read data is registered (1 cycle)
//   AES_START/AES_DONE  level start to core / completion flag from core
//   AES_KEY, AES_MSG_ENC  {reg0..reg3}, {reg4..reg7}
//   AES_MSG_DEC         plaintext from core
//   EXPORT_DATA         {reg0[31:16], reg3[15:0]} for the hex display
// Build option AES_REGS_IRQ_EN: adds AES_IRQ, set on entry to DONE, cleared
// by a reg 15 write with byte 0 enabled or by leaving DONE.
module aes_avalon_regs
  import aes_regs_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
`ifdef AES_REGS_IRQ_EN
  ,
  output logic         AES_IRQ
`endif
);

  aes_regs_state_t state_q, state_d;

  logic [31:0] word_q [8];
  logic [31:0] dec_q  [4];
  logic [31:0] cycles_q;
  logic [31:0] rdata_q, rdata_d;

  logic wr_en, rd_en, start_wr;
  logic aes_start, done_flag, capture, cyc_clr, cyc_inc;

  assign wr_en    = AVL_CS & AVL_WRITE;
  assign rd_en    = AVL_CS & AVL_READ;
  assign start_wr = wr_en && (AVL_ADDR == ADDR_START) && AVL_BYTE_EN[0];

  // Key/ciphertext words 0-7; locked while BUSY so the core sees stable inputs.
  for (genvar i = 0; i < 8; i++) begin : g_word
    aes_reg_word u_word (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .we_i      (wr_en && (AVL_ADDR == 4'(i))),
      .inhibit_i (state_q == ST_BUSY),
      .be_i      (AVL_BYTE_EN),
      .wdata_i   (AVL_WRITEDATA),
      .q_o       (word_q[i])
    );
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; in BUSY the abort is checked first so it beats AES_DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_wr && AVL_WRITEDATA[0])  state_d = ST_BUSY;
      ST_BUSY: begin
        if (start_wr && !AVL_WRITEDATA[0]) state_d = ST_IDLE;
        else if (AES_DONE)                 state_d = ST_DONE;
      end
      ST_DONE: if (start_wr && !AVL_WRITEDATA[0]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-derived controls
  always_comb begin
    aes_start = (state_q != ST_IDLE);
    done_flag = (state_q == ST_DONE);
    capture   = (state_q == ST_BUSY) && (state_d == ST_DONE);
    cyc_clr   = (state_q == ST_IDLE) && (state_d == ST_BUSY);
    cyc_inc   = (state_q == ST_BUSY);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycles_q <= '0;
      for (int unsigned k = 0; k < 4; k++) dec_q[k] <= '0;
    end else begin
      if (cyc_clr)                         cycles_q <= '0;
      else if (cyc_inc && cycles_q != '1)  cycles_q <= cycles_q + 32'd1;
      if (capture) begin
        dec_q[0] <= AES_MSG_DEC[127:96];
        dec_q[1] <= AES_MSG_DEC[95:64];
        dec_q[2] <= AES_MSG_DEC[63:32];
        dec_q[3] <= AES_MSG_DEC[31:0];
      end
    end
  end

  // Read mux samples pre-edge values, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (AVL_ADDR)
        ADDR_KEY0:    rdata_d = word_q[0];
        ADDR_KEY1:    rdata_d = word_q[1];
        ADDR_KEY2:    rdata_d = word_q[2];
        ADDR_KEY3:    rdata_d = word_q[3];
        ADDR_MSG0:    rdata_d = word_q[4];
        ADDR_MSG1:    rdata_d = word_q[5];
        ADDR_MSG2:    rdata_d = word_q[6];
        ADDR_MSG3:    rdata_d = word_q[7];
        ADDR_DEC0:    rdata_d = dec_q[0];
        ADDR_DEC1:    rdata_d = dec_q[1];
        ADDR_DEC2:    rdata_d = dec_q[2];
        ADDR_DEC3:    rdata_d = dec_q[3];
        ADDR_CYCLES:  rdata_d = cycles_q;
        ADDR_VERSION: rdata_d = VERSION;
        ADDR_START:   rdata_d = {31'd0, aes_start};
        ADDR_DONE:    rdata_d = {31'd0, done_flag};
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

`ifdef AES_REGS_IRQ_EN
  logic irq_q;
  always_ff @(posedge CLK) begin
    if (RESET)
      irq_q <= 1'b0;
    else if (capture)
      irq_q <= 1'b1;
    else if ((state_q == ST_DONE && state_d != ST_DONE) ||
             (wr_en && AVL_ADDR == ADDR_DONE && AVL_BYTE_EN[0]))
      irq_q <= 1'b0;
  end
  assign AES_IRQ = irq_q;
`endif

  assign AVL_READDATA = rdata_q;
  assign AES_START    = aes_start;
  assign AES_KEY      = {word_q[0], word_q[1], word_q[2], word_q[3]};
  assign AES_MSG_ENC  = {word_q[4], word_q[5], word_q[6], word_q[7]};
  assign EXPORT_DATA  = {word_q[0][31:16], word_q[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_regs.sv
module tb_aes_avalon_regs;

  logic         CLK = 1'b0;
  logic         RESET, AVL_CS, AVL_READ, AVL_WRITE, AES_DONE;
  logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
  logic         AES_START;
  logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
`ifdef AES_REGS_IRQ_EN
  logic         AES_IRQ;
`endif

  aes_avalon_regs dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AES_START(AES_START), .AES_DONE(AES_DONE), .AES_KEY(AES_KEY),
    .AES_MSG_ENC(AES_MSG_ENC), .AES_MSG_DEC(AES_MSG_DEC),
    .EXPORT_DATA(EXPORT_DATA)
`ifdef AES_REGS_IRQ_EN
    , .AES_IRQ(AES_IRQ)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference model: mode 0 = idle, 1 = busy, 2 = done
  logic [31:0] m_word [8];
  logic [31:0] m_dec  [4];
  logic [31:0] m_cycles;
  int          m_mode;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_word[i] = '0;
    for (int i = 0; i < 4; i++) m_dec[i] = '0;
    m_cycles = '0;
    m_mode   = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int ai = int'(a);
    if (ai < 8)   return m_word[ai];
    if (ai < 12)  return m_dec[ai-8];
    if (ai == 12) return m_cycles;
    if (ai == 13) return 32'h0385_0009;
    if (ai == 14) return (m_mode != 0) ? 32'd1 : 32'd0;
    return (m_mode == 2) ? 32'd1 : 32'd0;
  endfunction

  task automatic model_update(input bit cs, input bit wr, input logic [3:0] a,
                              input logic [3:0] be, input logic [31:0] wd,
                              input bit dn, input logic [127:0] dec);
    bit we    = cs && wr;
    bit go    = we && a == 4'd14 && be[0] && wd[0];
    bit abort = we && a == 4'd14 && be[0] && !wd[0];
    int ai    = int'(a);
    if (m_mode == 1 && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    if (we && ai < 8 && m_mode != 1)
      for (int b = 0; b < 4; b++)
        if (be[b]) m_word[ai][8*b +: 8] = wd[8*b +: 8];
    case (m_mode)
      0: if (go) begin m_mode = 1; m_cycles = 0; end
      1: if (abort) m_mode = 0;
         else if (dn) begin
           m_mode = 2;
           m_dec[0] = dec[127:96]; m_dec[1] = dec[95:64];
           m_dec[2] = dec[63:32];  m_dec[3] = dec[31:0];
         end
      default: if (abort) m_mode = 0;
    endcase
  endtask

  task automatic step(input bit rst, input bit cs, input bit rd, input bit wr,
                      input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input bit dn, input logic [127:0] dec);
    logic [31:0] exp_rd;
    RESET = rst; AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = a;
    AVL_BYTE_EN = be; AVL_WRITEDATA = wd; AES_DONE = dn; AES_MSG_DEC = dec;
    exp_rd = (!rst && cs && rd) ? model_read(a) : 32'd0;
    if (rst) model_reset();
    else     model_update(cs, wr, a, be, wd, dn, dec);
    @(posedge CLK); #1;
    check_eq("readdata", {96'd0, AVL_READDATA}, {96'd0, exp_rd});
    check_eq("aes_start", {127'd0, AES_START}, {127'd0, m_mode != 0});
    check_eq("aes_key", AES_KEY, {m_word[0], m_word[1], m_word[2], m_word[3]});
    check_eq("aes_msg_enc", AES_MSG_ENC, {m_word[4], m_word[5], m_word[6], m_word[7]});
    check_eq("export", {96'd0, EXPORT_DATA}, {96'd0, m_word[0][31:16], m_word[3][15:0]});
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
    step(0, 1, 0, 1, a, be, wd, 0, '0);
  endtask
  task automatic do_rd(input logic [3:0] a);
    step(0, 1, 1, 0, a, 4'h0, '0, 0, '0);
  endtask
  task automatic do_idle(input bit dn, input logic [127:0] dec);
    step(0, 0, 0, 0, 4'h0, 4'h0, '0, dn, dec);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, enc_before;
    logic [31:0]  snap [4];
    model_reset();
    @(negedge CLK);

    // Reset state and register readback
    step(1, 0, 0, 0, 4'h0, 4'h0, '0, 0, '0);
    check_eq("rst_start", {127'd0, AES_START}, 128'd0);
    for (int a = 0; a < 16; a++) do_rd(4'(a));
    do_rd(4'd13);
    check_eq("version", {96'd0, AVL_READDATA}, {96'd0, 32'h0385_0009});

    // Load key and ciphertext, start, run core for 40 cycles
    for (int i = 0; i < 4; i++) begin
      logic [31:0] kw;
      kw = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      do_wr(4'(i), 4'hF, kw);
      do_wr(4'(i+4), 4'hF, $urandom);
    end
    check_eq("key_const", AES_KEY, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    enc_before = AES_MSG_ENC;
    do_wr(4'd14, 4'h1, 32'd1);
    check_eq("start_rise", {127'd0, AES_START}, 128'd1);
    pt = rand128();
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) step(0, 1, 0, 1, 4'd4, 4'hF, 32'hDEAD_BEEF, 0, '0);
      else         do_idle(k == 40, (k == 40) ? pt : rand128());
    end
    check_eq("busy_lockout", AES_MSG_ENC, enc_before);
    for (int a = 8; a < 12; a++) do_rd(4'(a));
    check_eq("dec3_const", {96'd0, AVL_READDATA}, {96'd0, pt[31:0]});
    do_rd(4'd12);
    check_eq("cycles40", {96'd0, AVL_READDATA}, 128'd40);
    do_rd(4'd15);
    check_eq("done_bit", {96'd0, AVL_READDATA}, 128'd1);
    do_wr(4'd14, 4'h1, 32'd0);

    // Byte enables
    do_wr(4'd0, 4'hF, 32'h1122_3344);
    do_wr(4'd0, 4'b0101, 32'hAABB_CCDD);
    do_rd(4'd0);
    check_eq("byte_en", {96'd0, AVL_READDATA}, {96'd0, 32'h11BB_33DD});

    // Abort racing AES_DONE
    for (int i = 0; i < 4; i++) snap[i] = m_dec[i];
    do_wr(4'd14, 4'h1, 32'd1);
    for (int k = 0; k < 5; k++) do_idle(0, '0);
    step(0, 1, 0, 1, 4'd14, 4'h1, 32'd0, 1, rand128());
    check_eq("abort_start", {127'd0, AES_START}, 128'd0);
    for (int a = 8; a < 12; a++) begin
      do_rd(4'(a));
      check_eq("abort_dec", {96'd0, AVL_READDATA}, {96'd0, snap[a-8]});
    end

    // Stale AES_DONE in idle, then reset mid-BUSY
    do_idle(1, rand128());
    do_wr(4'd14, 4'h1, 32'd1);
    for (int k = 0; k < 3; k++) do_idle(0, '0);
    step(1, 0, 0, 0, 4'h0, 4'h0, '0, 0, '0);
    check_eq("rst_busy_start", {127'd0, AES_START}, 128'd0);
    check_eq("rst_busy_key", AES_KEY, 128'd0);
    for (int a = 0; a < 16; a++) do_rd(4'(a));

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 2) step(1, 0, 0, 0, 4'h0, 4'h0, '0, 0, '0);
      else begin
        logic [3:0] a;
        int op = $urandom_range(0, 3);
        a = ($urandom_range(0, 9) < 3) ? 4'd14 : 4'($urandom_range(0, 15));
        step(0, r > 8, op == 0 || op == 2, op == 1 || op == 2, a,
             4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 7) == 0, rand128());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_avalon_regs.md
# aes_avalon_regs

Avalon-MM slave register file that sits directly upstream of the AES decryption core. It holds the 128-bit key and ciphertext written by the NIOS II software, drives the core's start/key/message inputs, and captures the plaintext when the core signals completion. It also reports status and decryption cycle count back to software.

## Interface
Parameters:
- CLK_DIV_UNUSED: none; the block has no parameters, and all constants live in the package.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock, shared with the AES core
- RESET  in  1  synchronous, active-high reset
- AVL_CS  in  1  Avalon chip select
- AVL_READ  in  1  read strobe, qualified by AVL_CS
- AVL_WRITE  in  1  write strobe, qualified by AVL_CS
- AVL_ADDR  in  4  word address 0–15
- AVL_BYTE_EN  in  4  byte enables for writes
- AVL_WRITEDATA  in  32  write data
- AVL_READDATA  out  32  registered read data
- AES_START  out  1  level start to core
- AES_DONE  in  1  core completion flag
- AES_KEY  out  128  {reg0,reg1,reg2,reg3}
- AES_MSG_ENC  out  128  {reg4,reg5,reg6,reg7}
- AES_MSG_DEC  in  128  core plaintext output
- EXPORT_DATA  out  32  {reg0[31:16], reg3[15:0]} for the hex display

## Operation
Register map:
- 0–3: key, read/write.
- 4–7: ciphertext, read/write.
- 8–11: plaintext, read-only.
- 12: CYCLES, read-only.
- 13: VERSION = 32'h0385_0009, read-only.
- 14: START, only bit0 writable; other bits read 0.
- 15: DONE, bit0 is status; read-only.

Writes:
- A write requires AVL_CS & AVL_WRITE.
- Only bytes with AVL_BYTE_EN set are updated.
- Writes to read-only addresses are ignored.
- Writes to regs 0–7 are ignored while the state is BUSY. This keeps the core's inputs stable.

State machine (enum in package) — IDLE, BUSY, DONE:
- IDLE → BUSY: a write to reg 14 with BYTE_EN[0] and WRITEDATA[0]=1. CYCLES clears to 0.
- BUSY, AES_DONE=1: latch AES_MSG_DEC into regs 8–11 (bits [127:96] go to reg8) and move to DONE.
- BUSY, write of START bit0=0: abort to IDLE. Plaintext is not captured.
- DONE → IDLE: write of START bit0=0. Regs 8–11 keep their values.
- Writing START=1 in BUSY or DONE has no effect.

Outputs and counter:
- AES_START = state is BUSY or DONE.
- DONE bit0 = state is DONE.
- START bit0 reads back the AES_START level.
- CYCLES increments on each BUSY cycle and saturates at 32'hFFFF_FFFF.

Simultaneous events:
- An abort write and AES_DONE in the same BUSY cycle: the abort wins and nothing is captured.
- A read and a write to the same address in the same cycle: the read returns the old value.

## Timing
- Reset: all registers, CYCLES, AVL_READDATA, and AES_START are 0; state is IDLE; EXPORT_DATA is 0. Reset mid-BUSY drops AES_START on the next edge.
- Read latency is 1 cycle. AVL_READDATA is valid on the cycle after AVL_CS & AVL_READ, and is 0 on cycles with no read.
- A write takes effect at the edge that samples it.
- AES_START rises 1 cycle after the START write.
- Plaintext registers and DONE update at the edge where AES_DONE is sampled high, so they are readable 1 cycle later.
- AES_DONE is sampled only in BUSY. A stale AES_DONE=1 in IDLE is ignored.

## Configuration
- AES_REGS_IRQ_EN defined: adds output port AES_IRQ (1 bit, reset 0).
  - It is set at the same edge as the DONE transition.
  - It is cleared by a write to reg 15 with any data and BYTE_EN[0]=1, or by leaving DONE.
- Not defined: the AES_IRQ port is absent, and writes to reg 15 are ignored.

## Structure
- Package aes_regs_pkg holds:
  - address localparams: ADDR_KEY0..3, ADDR_MSG0..3, ADDR_DEC0..3, ADDR_CYCLES, ADDR_VERSION, ADDR_START, ADDR_DONE
  - the VERSION constant
  - the aes_regs_state_t enum
- One sub-module, aes_reg_word: a 32-bit register with byte-enabled write, a write-inhibit input, and a synchronous clear. It is instantiated for regs 0–7.

## Test plan
- Reset: after RESET, reading addrs 0–15 returns 0, except addr 13, which returns 32'h0385_0009. AES_START=0.
- Load key and message, then start:
  - Write key 000102…0F and ciphertext, then write reg14 = 1.
  - AES_START rises on the next cycle. AES_KEY = 128'h00010203_04050607_08090A0B_0C0D0E0F.
  - The core model raises AES_DONE after 40 cycles. Regs 8–11 then equal its AES_MSG_DEC, DONE reads 1, and CYCLES reads 40.
- Byte enables: write 32'hAABBCCDD to reg0 with BYTE_EN=4'b0101 over 32'h11223344. Reg0 reads 32'h11BB33DD.
- Busy lockout: a write to reg4 during BUSY leaves AES_MSG_ENC unchanged.
- Abort race: write START=0 in the same cycle AES_DONE rises. The state becomes IDLE and regs 8–11 are unchanged.
- Reset mid-BUSY: assert RESET during BUSY. All registers and AES_START are 0 on the next cycle.
